// File: rtl/watch_input_ctrl.sv
// Push-button front end for the watch controller: synchronise, debounce and edge-detect seven
// buttons, run the mode/set state machine. Define AUTO_REPEAT_EN for held-button repeat on btn_up.
module watch_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_next,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_reset,
    output logic [2:0] mode,
    output logic       setValue,
    output logic       upTime,
    output logic       nextd,
    output logic       start_resume,
    output logic       stop,
    output logic       resetTime
);

    localparam int unsigned NumBtn   = 7;
    localparam int unsigned IdxMode  = 0;
    localparam int unsigned IdxSet   = 1;
    localparam int unsigned IdxUp    = 2;
    localparam int unsigned IdxNext  = 3;
    localparam int unsigned IdxStart = 4;
    localparam int unsigned IdxStop  = 5;
    localparam int unsigned IdxReset = 6;

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ModeWatch     = 3'b000;
    localparam logic [2:0] ModeStopwatch = 3'b001;
    localparam logic [2:0] ModeDay       = 3'b011;

    typedef enum logic [0:0] {
        StNormal,
        StSet
    } state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    logic [NumBtn-1:0] deb_q;
    logic [NumBtn-1:0] deb_dly_q;
    logic [CNT_W-1:0]  cnt_q [NumBtn];
    logic [NumBtn-1:0] press;
    logic              rep_fire;
    state_e            state_q;

    assign btn_raw = {btn_reset, btn_stop, btn_start, btn_next, btn_up, btn_set, btn_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles where the synchronised input disagrees with the debounced level;
    // any agreeing cycle restarts the count, so short glitches never reach the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < NumBtn; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_dly_q <= deb_q;
            for (int i = 0; i < NumBtn; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DebLast) begin
                    deb_q[i] <= ~deb_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt_q;
    logic             rep_periodic_q;

    // First repeat waits the longer delay, every later one the shorter period.
    assign rep_fire = deb_q[IdxUp] && !press[IdxUp] &&
                      (rep_cnt_q == (rep_periodic_q ? PeriodLast : DelayLast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b0;
        end else if (!deb_q[IdxUp] || press[IdxUp]) begin
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b1;
        end else begin
            rep_cnt_q <= rep_cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upTime       <= 1'b0;
            nextd        <= 1'b0;
            start_resume <= 1'b0;
            stop         <= 1'b0;
            resetTime    <= 1'b0;
        end else begin
            upTime       <= press[IdxUp] | rep_fire;
            nextd        <= press[IdxNext];
            start_resume <= press[IdxStart];
            stop         <= press[IdxStop];
            resetTime    <= press[IdxReset];
        end
    end

    // Mode press takes priority in NORMAL; in SET the mode is frozen and only set is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StNormal;
            mode     <= ModeWatch;
            setValue <= 1'b0;
        end else begin
            unique case (state_q)
                StNormal: begin
                    if (press[IdxMode]) begin
                        mode <= (mode == ModeDay) ? ModeWatch : mode + 3'd1;
                    end else if (press[IdxSet] && (mode != ModeStopwatch)) begin
                        state_q  <= StSet;
                        setValue <= 1'b1;
                    end
                end
                StSet: begin
                    if (press[IdxSet]) begin
                        state_q  <= StNormal;
                        setValue <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StNormal;
                    setValue <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_input_ctrl.sv
// Directed bench for watch_input_ctrl with a window-based reference model checked every cycle.
module tb_watch_input_ctrl;

    localparam int D = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] drv   = '0;
    logic [2:0] mode;
    logic       setValue, upTime, nextd, start_resume, stop, resetTime;

    always #5 clk = ~clk;

    watch_input_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode     (drv[0]),
        .btn_set      (drv[1]),
        .btn_up       (drv[2]),
        .btn_next     (drv[3]),
        .btn_start    (drv[4]),
        .btn_stop     (drv[5]),
        .btn_reset    (drv[6]),
        .mode         (mode),
        .setValue     (setValue),
        .upTime       (upTime),
        .nextd        (nextd),
        .start_resume (start_resume),
        .stop         (stop),
        .resetTime    (resetTime)
    );

    // Model: a level flips once the last D synchronised samples (raw delayed two edges) all
    // disagree with it; presses are the registered rising edges of that level.
    logic [D:0] m_win [7];
    logic [6:0] m_deb, m_debp, m_flip, m_press;
    logic [4:0] m_pulse;
    logic       m_setv, m_rep;
    int         m_mode, m_hold;

    always_comb begin
        m_flip  = '0;
        m_press = '0;
        m_rep   = 1'b0;
        for (int b = 0; b < 7; b++) begin
            m_flip[b]  = (m_win[b][D:1] == {D{~m_deb[b]}});
            m_press[b] = m_deb[b] & ~m_debp[b];
        end
`ifdef AUTO_REPEAT_EN
        m_rep = m_deb[2] && !m_press[2] && (m_hold + 1 >= 64) && ((m_hold + 1 - 64) % 16 == 0);
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 7; b++) m_win[b] <= '0;
            m_deb   <= '0;
            m_debp  <= '0;
            m_pulse <= '0;
            m_mode  <= 0;
            m_setv  <= 1'b0;
            m_hold  <= 0;
        end else begin
            for (int b = 0; b < 7; b++) m_win[b] <= {m_win[b][D-1:0], drv[b]};
            m_deb   <= m_deb ^ m_flip;
            m_debp  <= m_deb;
            m_pulse <= {m_press[6:3], m_press[2] | m_rep};
            m_hold  <= m_press[2] ? 0 : m_hold + 1;
            if (m_setv) begin
                if (m_press[1]) m_setv <= 1'b0;
            end else if (m_press[0]) begin
                m_mode <= (m_mode + 1) % 4;
            end else if (m_press[1] && m_mode != 1) begin
                m_setv <= 1'b1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dut_cnt [5] = '{0, 0, 0, 0, 0};
    int m_cnt [5] = '{0, 0, 0, 0, 0};
    int dut_last [5] = '{0, 0, 0, 0, 0};
    int m_last [5] = '{0, 0, 0, 0, 0};

    // Pulse index order: 0 up, 1 next, 2 start, 3 stop, 4 reset.
    initial forever begin
        logic [9:0] dv, mv;
        logic [4:0] dp;
        @(posedge clk);
        cyc++;
        #1;
        dp = {resetTime, stop, start_resume, nextd, upTime};
        dv = {mode, setValue, upTime, nextd, start_resume, stop, resetTime};
        mv = {m_mode[2:0], m_setv, m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3], m_pulse[4]};
        for (int k = 0; k < 5; k++) begin
            if (dp[k]) begin dut_cnt[k]++; dut_last[k] = cyc; end
            if (m_pulse[k]) begin m_cnt[k]++; m_last[k] = cyc; end
        end
        vectors++;
        if (dv !== mv) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got %b expected %b", cyc, dv, mv);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [6:0] m);
        drv = m;
        tick(25);
        drv = '0;
        tick(25);
    endtask

    initial begin
        int e0, before_cnt [5], before_up, before_next;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("reset_mode", mode, 0);
        check("reset_setValue", setValue, 0);

        // Glitch of 10 cycles is shorter than the debounce window
        drv[2] = 1'b1;
        tick(10);
        drv[2] = 1'b0;
        tick(30);
        check("glitch_up_dut", dut_cnt[0], 0);
        check("glitch_up_model", m_cnt[0], 0);
        check("glitch_mode", mode, 0);
        check("glitch_setValue", setValue, 0);

        // Clean press: pulse after edge 19, none on release
        e0 = cyc;
        drv[4] = 1'b1;
        tick(30);
        drv[4] = 1'b0;
        tick(40);
        check("start_count", dut_cnt[2], 1);
        check("start_edge", dut_last[2] - e0, 19);
        check("start_edge_model", m_last[2] - e0, 19);

        // Mode wrap with an ignored set press in STOPWATCH
        press(7'b0000001); check("wrap_mode1", mode, 1);
        press(7'b0000010); check("sw_set_ignored", setValue, 0);
        check("sw_set_model", m_setv, 0);
        press(7'b0000001); check("wrap_mode2", mode, 2);
        press(7'b0000001); check("wrap_mode3", mode, 3);
        press(7'b0000001); check("wrap_mode0", mode, 0);
        check("wrap_model", m_mode, 0);

        // Set-mode locking at ALARM
        press(7'b0000001);
        press(7'b0000001);
        press(7'b0000010); check("set_enter", setValue, 1);
        press(7'b0000001); check("set_mode_frozen", mode, 2);
        check("set_still", setValue, 1);
        press(7'b0000010); check("set_exit", setValue, 0);
        check("set_exit_mode", mode, 2);

        // Simultaneous mode+set in NORMAL, then in SET
        press(7'b0000001);
        press(7'b0000001); check("back_to_watch", mode, 0);
        press(7'b0000011); check("sim_normal_mode", mode, 1);
        check("sim_normal_setv", setValue, 0);
        press(7'b0000001);
        press(7'b0000010); check("sim_pre_set", setValue, 1);
        press(7'b0000011); check("sim_set_mode", mode, 2);
        check("sim_set_setv", setValue, 0);

        // Simultaneous pass-through presses
        for (int k = 0; k < 5; k++) before_cnt[k] = dut_cnt[k];
        press(7'b1111100);
        for (int k = 0; k < 5; k++) check($sformatf("pass_ch%0d", k), dut_cnt[k] - before_cnt[k], 1);

        // Long hold of btn_up
        before_up = dut_cnt[0];
        drv[2] = 1'b1;
        tick(200);
        drv[2] = 1'b0;
        tick(40);
`ifdef AUTO_REPEAT_EN
        check("hold_up_pulses", dut_cnt[0] - before_up, 10);
`else
        check("hold_up_pulses", dut_cnt[0] - before_up, 1);
`endif

        // Async reset mid-debounce
        before_next = dut_cnt[1];
        drv[3] = 1'b1;
        tick(8);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {mode, setValue, upTime, nextd, start_resume, stop, resetTime}, 0);
        drv = '0;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check("post_rst_no_next", dut_cnt[1] - before_next, 0);
        check("post_rst_mode", mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
